// File: rtl/comp_pkg.sv
// Shared types and constants for the LSB-first serial comparator.
package comp_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/digit_comp_lsb.sv
// One LSB-first comparison step: a differing digit overrides the running flags,
// an equal digit passes them through unchanged.
module digit_comp_lsb
    import comp_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               eq_in,
    input  logic               gt_in,
    input  logic               signed_d,
    output logic               eq_out,
    output logic               gt_out
);

    logic [DIGIT_W-1:0] a_k;
    logic [DIGIT_W-1:0] b_k;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    always_comb begin
        a_k = a_d;
        b_k = b_d;
        if (signed_d) begin
            a_k[DIGIT_W-1] = ~a_d[DIGIT_W-1];
            b_k[DIGIT_W-1] = ~b_d[DIGIT_W-1];
        end
    end

    always_comb begin
        eq_out = eq_in;
        gt_out = gt_in;
        if (a_k > b_k) begin
            eq_out = 1'b0;
            gt_out = 1'b1;
        end else if (a_k < b_k) begin
            eq_out = 1'b0;
            gt_out = 1'b0;
        end
    end

endmodule

// File: rtl/serial_comp.sv
// Serial magnitude comparator, one 2-bit digit per cycle, LSB first.
// Define SERIAL_COMP_SIGNED_EN to compare operands as two's complement.
module serial_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Eq_o,
    output logic             Gt_o
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               eq_r;
    logic               gt_r;
    logic               eq_nx;
    logic               gt_nx;
    logic               last_digit;
    logic               signed_d;
    logic               accept;
    logic               consume;

    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign last_digit = (cnt == LAST);

`ifdef SERIAL_COMP_SIGNED_EN
    assign signed_d = last_digit;
`else
    assign signed_d = 1'b0;
`endif

    digit_comp_lsb u_digit (
        .a_d      (a_sh[DIGIT_W-1:0]),
        .b_d      (b_sh[DIGIT_W-1:0]),
        .eq_in    (eq_r),
        .gt_in    (gt_r),
        .signed_d (signed_d),
        .eq_out   (eq_nx),
        .gt_out   (gt_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)     next_state = RUN;
            RUN:     if (last_digit) next_state = DONE;
            DONE:    if (consume)    next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Flags are masked outside DONE so a partial or aborted result never shows.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        Eq_o      = out_valid && eq_r;
        Gt_o      = out_valid && gt_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            eq_r <= 1'b1;
            gt_r <= 1'b0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            cnt  <= '0;
            eq_r <= 1'b1;
            gt_r <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> DIGIT_W;
            b_sh <= b_sh >> DIGIT_W;
            cnt  <= cnt + CNT_W'(1);
            eq_r <= eq_nx;
            gt_r <= gt_nx;
        end
    end

endmodule

// File: tb/tb_serial_comp.sv
// Self-checking bench for serial_comp: directed corner cases plus random
// operands against an arithmetic reference (honours SERIAL_COMP_SIGNED_EN).
module tb_serial_comp;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic             Eq_o;
    logic             Gt_o;

    int total = 0;
    int bad   = 0;

    serial_comp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Eq_o      (Eq_o),
        .Gt_o      (Gt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word comparison, {eq, gt}.
    function automatic logic [1:0] refCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic gt;
`ifdef SERIAL_COMP_SIGNED_EN
        gt = ($signed(a) > $signed(b));
`else
        gt = (a > b);
`endif
        return {a == b, gt};
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic checkLatency(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Accepts one operand pair, scrambles the inputs afterwards and waits for the result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        int w;
        int lat;
        logic [1:0] expv;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_in_ready_before"}, in_ready, 1'b1);
        in_valid = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        checkOutput({tag, "_in_ready_busy"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkLatency({tag, "_latency"}, lat, WIDTH / 2);
        expv = refCompare(a, b);
        checkOutput({tag, "_eq"}, Eq_o, expv[1]);
        checkOutput({tag, "_gt"}, Gt_o, expv[0]);
    endtask

    task automatic consumeResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_after_take"}, out_valid, 1'b0);
        checkOutput({tag, "_ready_after_take"}, in_ready, 1'b1);
        checkOutput({tag, "_eq_masked"}, Eq_o, 1'b0);
        checkOutput({tag, "_gt_masked"}, Gt_o, 1'b0);
    endtask

    initial begin
        logic [1:0] held;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int stall;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_eq", Eq_o, 1'b0);
        checkOutput("reset_gt", Gt_o, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed operand pairs");
        applyStimulus(8'h5A, 8'h5A, "equal_5a");
        consumeResult("equal_5a");
        applyStimulus(8'h01, 8'h00, "lsb_gt");
        consumeResult("lsb_gt");
        applyStimulus(8'h10, 8'h0F, "high_override");
        consumeResult("high_override");
        applyStimulus(8'h80, 8'h7F, "sign_boundary");
        consumeResult("sign_boundary");
        applyStimulus(8'h00, 8'hFF, "zero_vs_ff");
        consumeResult("zero_vs_ff");

        $display("[TB] result held while consumer stalls");
        applyStimulus(8'hC3, 8'h3C, "stall");
        held = refCompare(8'hC3, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                A = 8'h3C;
                B = 8'hC3;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("stall_valid", out_valid, 1'b1);
            checkOutput("stall_in_ready", in_ready, 1'b0);
            checkOutput("stall_eq", Eq_o, held[1]);
            checkOutput("stall_gt", Gt_o, held[0]);
        end
        consumeResult("stall");

        $display("[TB] reset during RUN");
        in_valid = 1'b1;
        A = 8'hFF;
        B = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_out_valid", out_valid, 1'b0);
        checkOutput("abort_in_ready", in_ready, 1'b1);
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_no_result", out_valid, 1'b0);
        end
        applyStimulus(8'h03, 8'h07, "after_abort");
        consumeResult("after_abort");

        $display("[TB] random operand pairs");
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom);
            rb = (n % 4 == 0) ? ra : 8'($urandom);
            applyStimulus(ra, rb, "random");
            held  = refCompare(ra, rb);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                checkOutput("random_hold_valid", out_valid, 1'b1);
                checkOutput("random_hold_gt", Gt_o, held[0]);
            end
            consumeResult("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
